// File: rtl/fp_normalize_pack_module.sv
// Iterative normalizer and IEEE-754 packer for the FP adder back end.
// Optional ties-to-even rounding of the carry right shift: define FP_NORM_ROUND_EN.
module fp_normalize_pack_module #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    S_result,
    input  logic [FRAC_W+1:0]       Mantissa_result,
    input  logic [EXP_W-1:0]        Exponent_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [EXP_W:0]        EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]        EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [FRAC_W+1:0]     MANT_ONE = {{(FRAC_W+1){1'b0}}, 1'b1};
    localparam logic [FRAC_W-1:0]     FRAC_ZERO = '0;
    localparam logic [EXP_W+FRAC_W-1:0] MAG_ZERO = '0;

    logic [1:0]              state_q, state_d;
    logic [FRAC_W+1:0]       mant_q, mant_d;
    logic [EXP_W:0]          exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic [EXP_W+FRAC_W:0]   result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    zero_q, zero_d;

    logic [FRAC_W+1:0]       shiftMant;
    logic [FRAC_W+1:0]       rightMant;
    logic [EXP_W:0]          expInc;
    logic [EXP_W:0]          expDec;

    assign shiftMant = mant_q >> 1;
    assign expInc    = exp_q + EXP_ONE;
    assign expDec    = exp_q - EXP_ONE;

`ifdef FP_NORM_ROUND_EN
    // The bit dropped by the carry shift acts as guard; round half to even.
    logic guardBit;
    assign guardBit  = mant_q[0];
    assign rightMant = (guardBit && shiftMant[0]) ? (shiftMant + MANT_ONE) : shiftMant;
`else
    assign rightMant = shiftMant;
`endif

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = S_result;
                    mant_d  = Mantissa_result;
                    exp_d   = {1'b0, Exponent_in};
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    state_d  = DONE;
                end else if (mant_q[FRAC_W+1]) begin
                    mant_d = rightMant;
                    exp_d  = expInc;
                    if (expInc >= EXP_MAX) begin
                        result_d = {sign_q, EXP_MAX[EXP_W-1:0], FRAC_ZERO};
                        ovf_d    = 1'b1;
                        state_d  = DONE;
                    end
                end else if (mant_q[FRAC_W]) begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
                    state_d  = DONE;
                end else if (exp_q <= EXP_ONE) begin
                    // No denormal support: flush to signed zero.
                    result_d = {sign_q, MAG_ZERO};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = expDec;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize_pack_module.sv
// Scoreboard bench for fp_normalize_pack_module: stimulus pushes expectations,
// a monitor pops and compares when the DUT presents out_valid.
module tb_fp_normalize_pack_module;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        S_result;
    logic [24:0] Mantissa_result;
    logic [7:0]  Exponent_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zro;
        int          lat;
        int          accCyc;
    } expT;

    expT sbQ[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    bit  seen       = 0;

    fp_normalize_pack_module #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .S_result        (S_result),
        .Mantissa_result (Mantissa_result),
        .Exponent_in     (Exponent_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result),
        .overflow        (overflow),
        .underflow       (underflow),
        .zero            (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: compare once per presented result, on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            expT e;
            seen = 1'b1;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                checkOutput("underflow", {31'd0, underflow}, {31'd0, e.unf});
                checkOutput("zero", {31'd0, zero}, {31'd0, e.zro});
                checkOutput("latency", cyc - e.accCyc, e.lat);
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic waitIdle(input int maxCycles);
        bit ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (in_ready && sbQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic applyStimulus(input logic s, input logic [24:0] m, input logic [7:0] e,
                                 input logic [31:0] expRes, input logic eo, input logic eu,
                                 input logic ez, input int lat, input bit push);
        expT x;
        @(negedge clk);
        in_valid        = 1'b1;
        S_result        = s;
        Mantissa_result = m;
        Exponent_in     = e;
        @(posedge clk);
        #1;
        x.res = expRes; x.ovf = eo; x.unf = eu; x.zro = ez; x.lat = lat; x.accCyc = cyc;
        if (push) sbQ.push_back(x);
        in_valid        = 1'b0;
        S_result        = 1'b0;
        Mantissa_result = '0;
        Exponent_in     = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst             = 1'b0;
        in_valid        = 1'b0;
        S_result        = 1'b0;
        Mantissa_result = '0;
        Exponent_in     = '0;
        out_ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_flags", {29'd0, overflow, underflow, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(0, 25'h0800000, 8'h80, 32'h40000000, 0, 0, 0, 1, 1);  waitIdle(40);
        applyStimulus(0, 25'h1000000, 8'd127, 32'h40000000, 0, 0, 0, 2, 1); waitIdle(40);
        applyStimulus(1, 25'h1000000, 8'd254, 32'hFF800000, 1, 0, 0, 1, 1); waitIdle(40);
        applyStimulus(1, 25'h0000001, 8'd127, 32'hB4000000, 0, 0, 0, 24, 1); waitIdle(60);
        applyStimulus(1, 25'h0000001, 8'd5, 32'h80000000, 0, 1, 0, 5, 1);  waitIdle(40);
        applyStimulus(0, 25'h0800000, 8'd1, 32'h00800000, 0, 0, 0, 1, 1);  waitIdle(40);
        applyStimulus(0, 25'h0400000, 8'd2, 32'h00800000, 0, 0, 0, 2, 1);  waitIdle(40);
        applyStimulus(0, 25'h0400000, 8'd1, 32'h00000000, 0, 1, 0, 1, 1);  waitIdle(40);
`ifdef FP_NORM_ROUND_EN
        applyStimulus(0, 25'h1000003, 8'd127, 32'h40000002, 0, 0, 0, 2, 1); waitIdle(40);
        applyStimulus(0, 25'h1FFFFFF, 8'd127, 32'h40800000, 0, 0, 0, 3, 1); waitIdle(40);
`else
        applyStimulus(0, 25'h1000003, 8'd127, 32'h40000001, 0, 0, 0, 2, 1); waitIdle(40);
        applyStimulus(0, 25'h1FFFFFF, 8'd127, 32'h407FFFFF, 0, 0, 0, 2, 1); waitIdle(40);
`endif

        // Backpressure: zero result held while downstream stalls.
        out_ready = 1'b0;
        applyStimulus(1, 25'h0000000, 8'd100, 32'h00000000, 0, 0, 1, 1, 1);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) checkOutput("hold_wait_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_result", result, 32'h00000000);
            checkOutput("hold_zero", {31'd0, zero}, 32'd1);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("release_zero", {31'd0, zero}, 32'd0);
        waitIdle(10);

        // Abort a long normalization with reset mid-flight.
        applyStimulus(0, 25'h0000001, 8'd127, 32'h0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 25'h0C00000, 8'd130, 32'h41400000, 0, 0, 0, 1, 1); waitIdle(40);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
